// File: rtl/reg_write_arbiter.sv
// reg_write_arbiter: round-robin arbiter driving the shared register-bank write port
module reg_write_arbiter #(
  parameter int NREQ = 4,
  parameter int NREG = 32,
  parameter int AW = 5,
  parameter int DW = 32,
  parameter bit PROTECT_R0 = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    gnt,
  output logic [NREG-1:0]    wr_en,
  output logic [DW-1:0]      wr_data,
  output logic               busy,
  output logic [15:0]        wr_count
);
  localparam int PW = $clog2(NREQ);
  logic [PW-1:0] ptr, win, nxt;
  logic found;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_data;
  logic [NREG-1:0] en;
  always_comb begin
    found = 1'b0;
    win = '0;
    for (int k = 0; k < NREQ; k++)
      if (!found && req[(int'(ptr) + k) % NREQ] && !gnt[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        win = PW'((int'(ptr) + k) % NREQ);
      end
  end
  assign win_addr = req_addr[int'(win)*AW +: AW];
  assign win_data = req_data[int'(win)*DW +: DW];
  assign nxt = PW'((int'(win) + 1) % NREQ);
  assign en = (int'(win_addr) < NREG && !(PROTECT_R0 && win_addr == '0)) ? NREG'(1) << win_addr : '0;
  always_ff @(posedge clk)
    if (rst) begin
      gnt <= '0;
      wr_en <= '0;
      wr_data <= '0;
      busy <= 1'b0;
      wr_count <= '0;
      ptr <= '0;
    end else begin
      busy <= |req;
      gnt <= found ? NREQ'(1) << win : '0;
      wr_en <= found ? en : '0;
      if (found) begin
        wr_data <= win_data;
        ptr <= nxt;
        wr_count <= wr_count + 16'd1;
      end
    end
endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb_reg_write_arbiter: randomized and directed check of reg_write_arbiter against a behavioural model
module tb_reg_write_arbiter;
  localparam int NREQ = 4, AW = 5, DW = 32;
  logic clk = 1'b0, rst = 1'b1;
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] gnt, gnt2;
  logic [31:0] wr_en;
  logic [15:0] wr_en2;
  logic [DW-1:0] wr_data, wr_data2;
  logic busy, busy2;
  logic [15:0] wr_count, wr_count2;
  reg_write_arbiter dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .wr_en(wr_en), .wr_data(wr_data), .busy(busy), .wr_count(wr_count)
  );
  reg_write_arbiter #(.NREG(16), .PROTECT_R0(1'b0)) dut2 (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt2), .wr_en(wr_en2), .wr_data(wr_data2), .busy(busy2), .wr_count(wr_count2)
  );
  always #5 clk = ~clk;
  bit r_req[NREQ];
  logic [AW-1:0] r_addr[NREQ];
  logic [DW-1:0] r_data[NREQ];
  int m_gnt = -1, m_ptr = 0;
  logic [31:0] m_en = '0, m_data = '0;
  logic [15:0] m_en2 = '0, m_cnt = '0;
  logic m_busy = 1'b0;
  int errors = 0, checks = 0;
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < NREQ; i++) begin
      req[i] = r_req[i];
      req_addr[i*AW +: AW] = r_addr[i];
      req_data[i*DW +: DW] = r_data[i];
    end
  endtask
  task automatic model_step();
    int best, bd;
    logic [AW-1:0] a;
    best = -1;
    bd = NREQ;
    if (rst) begin
      m_gnt = -1; m_ptr = 0; m_en = '0; m_en2 = '0; m_data = '0; m_busy = 1'b0; m_cnt = '0;
    end else begin
      m_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) begin
        m_busy |= r_req[i];
        if (r_req[i] && i != m_gnt && (i - m_ptr + NREQ) % NREQ < bd) begin
          best = i;
          bd = (i - m_ptr + NREQ) % NREQ;
        end
      end
      m_gnt = best;
      m_en = '0;
      m_en2 = '0;
      if (best >= 0) begin
        a = r_addr[best];
        m_data = r_data[best];
        m_ptr = (best + 1) % NREQ;
        m_cnt = m_cnt + 16'd1;
        m_en = (a != 0) ? 32'd1 << a : '0;
        m_en2 = (a < 16) ? 16'd1 << a : '0;
      end
    end
  endtask
  task automatic tick();
    logic [31:0] eg;
    drive();
    model_step();
    @(posedge clk);
    #1;
    eg = (m_gnt < 0) ? '0 : 32'd1 << m_gnt;
    chk("gnt", 32'(gnt), eg);
    chk("gnt2", 32'(gnt2), eg);
    chk("wr_en", wr_en, m_en);
    chk("wr_en2", 32'(wr_en2), 32'(m_en2));
    chk("wr_data", wr_data, m_data);
    chk("wr_data2", wr_data2, m_data);
    chk("busy", 32'(busy), 32'(m_busy));
    chk("busy2", 32'(busy2), 32'(m_busy));
    chk("wr_count", 32'(wr_count), 32'(m_cnt));
    chk("wr_count2", 32'(wr_count2), 32'(m_cnt));
  endtask
  task automatic new_write(int i);
    r_req[i] = 1'b1;
    r_addr[i] = AW'($urandom);
    r_data[i] = $urandom;
  endtask
  task automatic clear();
    for (int i = 0; i < NREQ; i++) begin
      r_req[i] = 1'b0;
      r_addr[i] = '0;
      r_data[i] = '0;
    end
  endtask
  task automatic react(int mode);
    if (m_gnt >= 0) begin
      if (mode == 1 || (mode == 2 && $urandom_range(1) == 1)) new_write(m_gnt);
      else r_req[m_gnt] = 1'b0;
    end
    if (mode == 2)
      for (int i = 0; i < NREQ; i++)
        if (!r_req[i] && i != m_gnt && $urandom_range(2) == 0) new_write(i);
  endtask
  task automatic do_reset();
    rst = 1'b1;
    clear();
    tick();
    rst = 1'b0;
  endtask
  initial begin
    clear();
    for (int i = 0; i < NREQ; i++) new_write(i);
    rst = 1'b1;
    tick();
    tick();
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_wr_en", wr_en, 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    chk("reset_count", 32'(wr_count), 32'h0);
    rst = 1'b0;
    tick();
    chk("first_after_reset", 32'(gnt), 32'h1);
    do_reset();
    r_req[2] = 1'b1;
    r_addr[2] = 5'd7;
    r_data[2] = 32'hDEADBEEF;
    tick();
    chk("single_gnt", 32'(gnt), 32'h4);
    chk("single_wr_en", wr_en, 32'h80);
    chk("single_data", wr_data, 32'hDEADBEEF);
    chk("single_count", 32'(wr_count), 32'h1);
    r_req[2] = 1'b0;
    tick();
    do_reset();
    r_req[1] = 1'b1;
    r_addr[1] = 5'd3;
    r_data[1] = 32'h1234;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("stale_guard", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h0);
    end
    do_reset();
    r_req[0] = 1'b1;
    r_addr[0] = 5'd0;
    r_data[0] = 32'h5;
    tick();
    chk("prot_gnt", 32'(gnt), 32'h1);
    chk("prot_wr_en", wr_en, 32'h0);
    chk("prot_count", 32'(wr_count), 32'h1);
    chk("r0_open_wr_en2", 32'(wr_en2), 32'h1);
    r_req[0] = 1'b0;
    r_req[1] = 1'b1;
    r_addr[1] = 5'd31;
    r_data[1] = 32'h6;
    tick();
    chk("oor_gnt2", 32'(gnt2), 32'h2);
    chk("oor_wr_en2", 32'(wr_en2), 32'h0);
    chk("oor_wr_en", wr_en, 32'h80000000);
    chk("oor_count2", 32'(wr_count2), 32'h2);
    r_req[1] = 1'b0;
    tick();
    do_reset();
    new_write(0);
    new_write(3);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("ptr_wrap", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h8);
      react(1);
    end
    do_reset();
    for (int i = 0; i < NREQ; i++) new_write(i);
    for (int k = 0; k < 65535; k++) begin
      tick();
      if (k < 8) chk("rr_order", 32'(gnt), 32'd1 << (k % 4));
      react(1);
    end
    chk("count_ffff", 32'(wr_count), 32'hFFFF);
    tick();
    chk("count_wrap", 32'(wr_count), 32'h0);
    do_reset();
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(99) == 0);
      tick();
      react(2);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
